// File: rtl/usr_seq_ctrl_if.sv
// Command channel between a host and the USR command sequencer.
// Ports (signals):
//   cmd_valid  host -> ctrl  command present
//   cmd_ready  ctrl -> host  controller can accept a command
//   cmd_op     host -> ctrl  0 LOAD-only, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5-7 illegal
//   cmd_load   host -> ctrl  parallel-load cmd_data before stepping
//   cmd_data   host -> ctrl  parallel load value
//   cmd_count  host -> ctrl  number of shift/rotate steps
//   cmd_fill   host -> ctrl  serial fill bit for SHL/SHR
// Modports: master (host side), slave (controller side).
interface usr_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_load;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_data, cmd_count, cmd_fill,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_data, cmd_count, cmd_fill,
        output cmd_ready
    );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for an 8-bit universal shift register (USR).
// Accepts one command at a time (optional parallel load followed by N
// shift/rotate steps), drives the USR control pins and reports the final
// register value with a one-cycle done pulse.
// Ports:
//   clock       rising-edge system clock
//   reset       synchronous active-high reset
//   cmd         command channel (slave side of usr_seq_ctrl_if)
//   usr_q       USR current output
//   usr_in      USR parallel input (holds last loaded value)
//   usr_select  00 hold, 01 shift left, 10 shift right, 11 parallel load
//   usr_sinl    serial in entering bit WIDTH-1 on shift right
//   usr_sinr    serial in entering bit 0 on shift left
//   busy        command in progress
//   done        one-cycle completion pulse
//   err         valid with done; illegal op
//   result      final USR value, held until next done
module usr_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    usr_seq_ctrl_if.slave    cmd,
    input  logic [WIDTH-1:0] usr_q,
    output logic [WIDTH-1:0] usr_in,
    output logic [1:0]       usr_select,
    output logic             usr_sinl,
    output logic             usr_sinr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_SHL  = 3'd1,
        OP_SHR  = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4
    } op_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             fill_q;
    logic             err_q;

    logic accept;
    logic op_legal;
    logic op_load;
    logic op_steps;

    assign cmd.cmd_ready = (state == S_IDLE) && !reset;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign busy          = (state != S_IDLE);

    // Decode of the incoming command, used only on the accept edge.
    assign op_legal = (cmd.cmd_op <= OP_ROR);
    assign op_load  = cmd.cmd_load || (cmd.cmd_op == OP_LOAD);
    assign op_steps = (cmd.cmd_count != '0) && (cmd.cmd_op != OP_LOAD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            fill_q <= 1'b0;
            err_q  <= 1'b0;
            usr_in <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state <= state_d;
            done  <= (state == S_FIN);
            err   <= (state == S_FIN) && err_q;
            if (state == S_FIN) begin
                result <= usr_q;
            end
            if (accept) begin
                op_q   <= cmd.cmd_op;
                cnt    <= cmd.cmd_count;
                fill_q <= cmd.cmd_fill;
                err_q  <= !op_legal;
                // Illegal commands leave the USR pins untouched, usr_in included.
                if (op_legal && op_load) begin
                    usr_in <= cmd.cmd_data;
                end
            end else if (state == S_SHIFT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state;
        usr_select = 2'b00;
        usr_sinl   = 1'b0;
        usr_sinr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!op_legal) begin
                        state_d = S_FIN;
                    end else if (op_load) begin
                        state_d = S_LOAD;
                    end else if (op_steps) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                usr_select = 2'b11;
                // Only legal ops reach LOAD, so op != 0 means a shift/rotate.
                state_d = ((cnt != '0) && (op_q != OP_LOAD)) ? S_SHIFT : S_FIN;
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SHL: begin
                        usr_select = 2'b01;
                        usr_sinr   = fill_q;
                    end
                    OP_SHR: begin
                        usr_select = 2'b10;
                        usr_sinl   = fill_q;
                    end
                    OP_ROL: begin
                        usr_select = 2'b01;
                        usr_sinr   = usr_q[WIDTH-1];
                    end
                    OP_ROR: begin
                        usr_select = 2'b10;
                        usr_sinl   = usr_q[0];
                    end
                    default: usr_select = 2'b00;
                endcase
                if (cnt <= CNT_W'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench for usr_seq_ctrl. Contains a behavioural USR plant
// driven by the controller pins and a command-level reference model that
// computes expected result, err, latency and pin activity per command.
module tb_usr_seq_ctrl;
    localparam int W = 8;
    localparam int C = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] usr_reg = '0;
    logic [W-1:0] usr_in;
    logic [1:0]   usr_select;
    logic         usr_sinl;
    logic         usr_sinr;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_usr = '0;

    always #5 clock = ~clock;

    usr_seq_ctrl_if #(.WIDTH(W), .CNT_W(C)) cmd_if ();

    usr_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd        (cmd_if.slave),
        .usr_q      (usr_reg),
        .usr_in     (usr_in),
        .usr_select (usr_select),
        .usr_sinl   (usr_sinl),
        .usr_sinr   (usr_sinr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result)
    );

    // Universal shift register plant.
    always @(posedge clock) begin
        case (usr_select)
            2'b11:   usr_reg <= usr_in;
            2'b01:   usr_reg <= {usr_reg[W-2:0], usr_sinr};
            2'b10:   usr_reg <= {usr_sinl, usr_reg[W-1:1]};
            default: usr_reg <= usr_reg;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Command-level reference: what the register must hold afterwards and
    // how many cycles of each kind of USR activity the command implies.
    task automatic ref_cmd(input logic [2:0] op, input logic ld, input logic [W-1:0] data,
                           input logic [C-1:0] cnt, input logic fill, input logic [W-1:0] start,
                           output logic [W-1:0] res, output logic e, output int lat,
                           output int nload, output int nstep);
        logic [W-1:0] v;
        v = start;
        if (op > 3'd4) begin
            res = start; e = 1'b1; lat = 1; nload = 0; nstep = 0;
        end else begin
            e = 1'b0;
            nload = (ld || op == 3'd0) ? 1 : 0;
            if (nload == 1) v = data;
            nstep = (op != 3'd0) ? int'(cnt) : 0;
            for (int i = 0; i < nstep; i++) begin
                case (op)
                    3'd1:    v = {v[W-2:0], fill};
                    3'd2:    v = {fill, v[W-1:1]};
                    3'd3:    v = {v[W-2:0], v[W-1]};
                    default: v = {v[0], v[W-1:1]};
                endcase
            end
            res = v;
            lat = nload + nstep + 1;
        end
    endtask

    // Issue one command and check it end to end. With b2b set the task is
    // entered at the negedge of the previous done cycle.
    task automatic run_cmd(input logic [2:0] op, input logic ld, input logic [W-1:0] data,
                           input logic [C-1:0] cnt, input logic fill,
                           input bit b2b, input bit noise, input string name);
        logic [W-1:0] e_res;
        logic         e_err;
        int           e_lat, e_nload, e_nstep;
        int           guard, edges, n11, nstep, bad;
        bit           seen;
        logic [1:0]   dir;
        logic         ser, exp_ser;

        if (!b2b) begin
            @(negedge clock);
        end else begin
            vectors++;
            if (cmd_if.cmd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_b2b_ready: got %b expected 1", name, cmd_if.cmd_ready);
            end
        end
        cmd_if.cmd_op    = op;
        cmd_if.cmd_load  = ld;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_count = cnt;
        cmd_if.cmd_fill  = fill;
        cmd_if.cmd_valid = 1'b1;
        guard = 0;
        while (cmd_if.cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_accept: cmd_ready stayed %b, expected 1", name, cmd_if.cmd_ready);
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        ref_cmd(op, ld, data, cnt, fill, exp_usr, e_res, e_err, e_lat, e_nload, e_nstep);
        dir = (op == 3'd1 || op == 3'd3) ? 2'b01 : 2'b10;
        @(posedge clock);

        edges = 0; seen = 0; n11 = 0; nstep = 0; bad = 0;
        while (edges < 40) begin
            @(negedge clock);
            if (noise && edges < 2) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_op    = 3'($urandom_range(0, 7));
                cmd_if.cmd_data  = 8'($urandom);
                cmd_if.cmd_count = 4'($urandom);
            end else begin
                cmd_if.cmd_valid = 1'b0;
            end
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            case (usr_select)
                2'b11: begin
                    n11++;
                    if (usr_in !== data) bad++;
                end
                2'b01, 2'b10: begin
                    nstep++;
                    if (usr_select !== dir) bad++;
                    ser = (usr_select == 2'b01) ? usr_sinr : usr_sinl;
                    case (op)
                        3'd3:    exp_ser = usr_reg[W-1];
                        3'd4:    exp_ser = usr_reg[0];
                        default: exp_ser = fill;
                    endcase
                    if (ser !== exp_ser) bad++;
                end
                2'b00: begin
                    if (usr_sinl !== 1'b0 || usr_sinr !== 1'b0) bad++;
                end
                default: bad++;
            endcase
            @(posedge clock);
            edges++;
        end

        vectors++;
        if (!seen || edges != e_lat) begin
            miscompares++;
            $display("FAIL %s_latency: done after %0d edges (seen=%0d), expected %0d", name, edges, seen, e_lat);
        end
        vectors++;
        if (result !== e_res) begin
            miscompares++;
            $display("FAIL %s_result: got %h expected %h", name, result, e_res);
        end
        vectors++;
        if (err !== e_err) begin
            miscompares++;
            $display("FAIL %s_err: got %b expected %b", name, err, e_err);
        end
        vectors++;
        if (n11 != e_nload || nstep != e_nstep || bad != 0) begin
            miscompares++;
            $display("FAIL %s_pins: load cycles %0d/%0d step cycles %0d/%0d bad %0d (got/expected)",
                     name, n11, e_nload, nstep, e_nstep, bad);
        end
        vectors++;
        if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_idle: busy=%b ready=%b expected busy=0 ready=1", name, busy, cmd_if.cmd_ready);
        end
        exp_usr = e_res;
    endtask

    task automatic check_pulse_end(input string name);
        @(negedge clock);
        vectors++;
        if (done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_pulse: done=%b err=%b expected 0 0", name, done, err);
        end
    endtask

    task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = '0; cmd_if.cmd_load = 1'b0; cmd_if.cmd_data = '0;
        cmd_if.cmd_count = '0; cmd_if.cmd_fill = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 0", cmd_if.cmd_ready);
        end
        vectors++;
        if ({busy, done, err, usr_select, usr_sinl, usr_sinr} !== 7'b0 || result !== 8'h00 || usr_in !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b err=%b sel=%b sinl=%b sinr=%b result=%h usr_in=%h expected all 0",
                     busy, done, err, usr_select, usr_sinl, usr_sinr, result, usr_in);
        end
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_if.cmd_ready);
        end
    endtask

    task automatic test_load();
        run_cmd(3'd0, 1'b0, 8'h55, 4'd0, 1'b0, 0, 0, "load");
        check_val("load_const", result, 8'h55);
        check_pulse_end("load");
    endtask

    task automatic test_shl();
        run_cmd(3'd1, 1'b1, 8'h55, 4'd3, 1'b1, 0, 0, "shl");
        check_val("shl_const", result, 8'hAF);
    endtask

    task automatic test_ror_wrap();
        run_cmd(3'd4, 1'b1, 8'hAA, 4'd9, 1'b0, 0, 0, "ror9");
        check_val("ror9_const", result, 8'h55);
    endtask

    task automatic test_back_to_back();
        run_cmd(3'd2, 1'b0, 8'h00, 4'd2, 1'b0, 0, 0, "shr_noload");
        check_val("shr_noload_const", result, 8'h15);
        run_cmd(3'd3, 1'b1, 8'h81, 4'd2, 1'b0, 1, 0, "rol_b2b");
        check_val("rol_b2b_const", result, 8'h06);
        check_pulse_end("rol_b2b");
    endtask

    task automatic test_busy_ignore();
        run_cmd(3'd1, 1'b1, 8'h3C, 4'd5, 1'b0, 0, 1, "busy_ignore");
        check_pulse_end("busy_ignore");
    endtask

    task automatic test_reset_abort();
        bit stray;
        @(negedge clock);
        cmd_if.cmd_op = 3'd2; cmd_if.cmd_load = 1'b1; cmd_if.cmd_data = 8'hF0;
        cmd_if.cmd_count = 4'd6; cmd_if.cmd_fill = 1'b0; cmd_if.cmd_valid = 1'b1;
        @(posedge clock);          // accept
        @(negedge clock);          // LOAD
        cmd_if.cmd_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);          // SHIFT 1
        @(posedge clock);
        @(negedge clock);          // SHIFT 2
        vectors++;
        if (usr_select !== 2'b10 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_shifting: sel=%b busy=%b expected 10 1", usr_select, busy);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || usr_select !== 2'b00 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b sel=%b done=%b expected 0 00 0", busy, usr_select, done);
        end
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || usr_select !== 2'b00) stray = 1;
        end
        vectors++;
        if (stray) begin
            miscompares++;
            $display("FAIL abort_no_done: stray done or USR activity seen, expected none");
        end
        // Two shifts happened (end of SHIFT 1 and the reset edge); nothing restores them.
        check_val("abort_usr_kept", usr_reg, 8'h3C);
        exp_usr = 8'h3C;
    endtask

    task automatic test_illegal();
        run_cmd(3'd6, 1'b1, 8'hFF, 4'd3, 1'b1, 0, 0, "illegal");
        check_val("illegal_unchanged", result, 8'h3C);
        check_pulse_end("illegal");
    endtask

    task automatic test_random();
        bit b2b;
        for (int i = 0; i < 40; i++) begin
            b2b = (i != 0) && ($urandom_range(0, 1) == 1);
            run_cmd(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom),
                    4'($urandom), 1'($urandom), b2b, 0, "rand");
        end
        check_pulse_end("rand");
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_ror_wrap();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
Command sequencer for the 8-bit universal shift register (USR). It accepts one command at a time over a valid/ready handshake. Each command is an optional parallel load followed by N shift or rotate steps. The block drives the USR's select, serial-in and parallel-in pins, and returns the final register value with a done pulse. It sits between a host/FSM and the USR, so no client toggles select codes directly.

Parameters:
WIDTH, 8, USR data width
CNT_W, 4, width of shift-count field (max 15 steps per command)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  0 LOAD-only, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5-7 illegal
cmd_load  input  1  parallel-load cmd_data before stepping (forced 1 for op 0)
cmd_data  input  WIDTH  parallel load value
cmd_count  input  CNT_W  number of shift/rotate steps
cmd_fill  input  1  serial fill bit for SHL/SHR
usr_q  input  WIDTH  USR current output
usr_in  output  WIDTH  USR parallel input
usr_select  output  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
usr_sinl  output  1  USR serial in, enters bit WIDTH-1 on shift right
usr_sinr  output  1  USR serial in, enters bit 0 on shift left
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
err  output  1  valid with done; illegal op
result  output  WIDTH  final USR value, held until next done

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, FIN. All registers are captured on the rising clock edge. Outputs are decoded from registered state.
- Reset (synchronous, wins over everything): state=IDLE, step counter=0, done=0, err=0, result=0, usr_in=0, usr_select=00, usr_sinl=0, usr_sinr=0, busy=0.
- cmd_ready = (state==IDLE) && !reset. A command is accepted on the edge where cmd_valid && cmd_ready. cmd_valid while not ready is ignored, not queued.
- On accept, latch op, data, count and fill; busy=1.
  - If op is illegal: go to FIN with err latched.
  - Else if load (cmd_load or op 0): go to LOAD.
  - Else if count>0 and op is 1-4: go to SHIFT.
  - Else: go to FIN.
- LOAD (1 cycle): usr_select=11, usr_in=latched data.
  - Next state is SHIFT if count>0 and op is 1-4, else FIN.
- SHIFT (exactly count cycles; counter decrements each cycle; exit to FIN when the counter reaches 1):
  - SHL: select=01, sinr=fill.
  - SHR: select=10, sinl=fill.
  - ROL: select=01, sinr=usr_q[WIDTH-1].
  - ROR: select=10, sinl=usr_q[0].
  - Rotates with count>=WIDTH wrap naturally (effective count mod WIDTH). Shifts with count>=WIDTH yield all-fill.
- FIN (1 cycle): usr_select=00. At the end of this cycle: result<=usr_q, done<=1, err<=latched err, state->IDLE.
- done and err are high for exactly the first IDLE cycle after FIN; done is cleared the following cycle. cmd_ready is high in that same cycle, so back-to-back commands are legal.
- Latency: done is high in the cycle after acceptance edge + L + count + 1 edges, where L = 1 if a load is performed, else 0. Total occupancy is L + count + 1 cycles.
- Outside LOAD/SHIFT: usr_select=00, sinl=sinr=0, usr_in holds its last value. The USR is never disturbed while idle.
- Illegal op: no USR activity (select 00 throughout); result is updated with the unchanged usr_q.
- Reset mid-command: aborted next edge, no done pulse. USR contents are whatever was reached; the controller does not restore them.

Test Plan:
1. Reset 2 cycles, then LOAD op=0, data=0x55 → select 11 for 1 cycle, then 00. done 2 edges after accept; result=0x55, err=0.
2. SHL, load=1, data=0x55, count=3, fill=1 → select 11, then 01×3, then 00. done 5 edges after accept; result=0xAF.
3. ROR, load=1, data=0xAA, count=9 → 9 cycles of select=10 with sinl tracking usr_q[0]; result=0x55.
4. SHR, load=0, count=2, fill=0, with USR holding 0x55 → result=0x15. Issue a second command in the done cycle; it is accepted with no gap.
5. Pulse cmd_valid while busy → ignored. Assert reset during the 2nd SHIFT cycle → next cycle state IDLE, select=00, busy=0, no done.
6. op=6, data=0xFF, load=1 → no LOAD cycle, select stays 00. done 1 edge after accept with err=1; result=usr_q unchanged.
